// File: rtl/bm_pkg.sv
// Shared types and helpers for the bitonic-merge input packer.
package bm_pkg;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} pack_state_t;

  localparam int MAX_DW = 64;

  function automatic int lane_cnt(input int bm_width);
    return 2 * bm_width;
  endfunction

  function automatic int fill_w(input int bm_width);
    return ($clog2(2 * bm_width) < 1) ? 1 : $clog2(2 * bm_width);
  endfunction

  // Pads sort to the tail: max key when ascending, min key when descending.
  function automatic logic [MAX_DW-1:0] pad_val(input logic asc, input int dw);
    return asc ? ({MAX_DW{1'b1}} >> (MAX_DW - dw)) : '0;
  endfunction
endpackage

// File: rtl/bm_input_packer_if.sv
// Key stream in, packed vector out; slave modport is the packer's view.
interface bm_input_packer_if #(
  parameter int DATA_WIDTH = 4,
  parameter int BM_WIDTH   = 1
);
  logic [DATA_WIDTH-1:0]            s_data;
  logic                             s_valid;
  logic                             s_ready;
  logic                             s_last;
  logic                             dir_in;
  logic                             m_ready;
  logic [0:DATA_WIDTH*BM_WIDTH*2-1] a_in;
  logic                             x_valid;
  logic                             ASCENDING;
  logic                             last_stage_chann;

  modport slave (
    input  s_data, s_valid, s_last, dir_in, m_ready,
    output s_ready, a_in, x_valid, ASCENDING, last_stage_chann
  );
  modport master (
    output s_data, s_valid, s_last, dir_in, m_ready,
    input  s_ready, a_in, x_valid, ASCENDING, last_stage_chann
  );
endinterface

// File: rtl/bm_input_packer.sv
// Packs 2*BM_WIDTH keys into one vector behind a one-entry output register.
// Define BM_PACK_PAD_EN to close a group early on s_last and pad remaining lanes.
module bm_input_packer
  import bm_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int BM_WIDTH   = 1,
  parameter int LAST_STAGE = 0
) (
  input logic              clk,
  input logic              rst,
  bm_input_packer_if.slave bus
);
  localparam int N  = lane_cnt(BM_WIDTH);
  localparam int FW = fill_w(BM_WIDTH);
  localparam int VW = N * DATA_WIDTH;
  localparam logic [FW-1:0] LAST_LANE = FW'(N - 1);

  pack_state_t   state_q, state_d;
  logic [FW-1:0] fill_cnt;
  logic [0:VW-1] pack_q, vec_d, a_q;
  logic          dir_latch, asc_q, dir_cur;
  logic          fin_lane, grp_end, stall, in_xfer, complete;

  assign fin_lane = (fill_cnt == LAST_LANE);
  assign dir_cur  = (fill_cnt == '0) ? bus.dir_in : dir_latch;

`ifdef BM_PACK_PAD_EN
  logic [MAX_DW-1:0]     pad_full;
  logic [DATA_WIDTH-1:0] pad;
  assign pad_full = pad_val(dir_cur, DATA_WIDTH);
  assign pad      = pad_full[DATA_WIDTH-1:0];
  assign grp_end  = fin_lane || bus.s_last;
`else
  assign grp_end  = fin_lane;
`endif

  // Only a group-closing key needs the output slot; earlier keys always land.
  assign stall       = grp_end && (state_q == FULL) && !bus.m_ready;
  assign bus.s_ready = rst && !stall;
  assign in_xfer     = bus.s_valid && bus.s_ready;
  assign complete    = in_xfer && grp_end;

  always_comb begin
    vec_d = pack_q;
    for (int k = 0; k < N; k++) begin
      if (FW'(k) == fill_cnt)
        vec_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.s_data;
`ifdef BM_PACK_PAD_EN
      else if (FW'(k) > fill_cnt)
        vec_d[k*DATA_WIDTH +: DATA_WIDTH] = pad;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (complete) state_d = FULL;
      FULL:    if (complete) state_d = FULL;
               else if (bus.m_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_cnt  <= '0;
      pack_q    <= '0;
      a_q       <= '0;
      asc_q     <= 1'b0;
      dir_latch <= 1'b0;
    end else begin
      if (in_xfer) begin
        pack_q[int'(fill_cnt)*DATA_WIDTH +: DATA_WIDTH] <= bus.s_data;
        if (fill_cnt == '0) dir_latch <= bus.dir_in;
        fill_cnt <= grp_end ? '0 : fill_cnt + 1'b1;
      end
      if (complete) begin
        a_q   <= vec_d;
        asc_q <= dir_cur;
      end
    end
  end

  assign bus.a_in             = a_q;
  assign bus.x_valid          = (state_q == FULL);
  assign bus.ASCENDING        = asc_q;
  assign bus.last_stage_chann = (LAST_STAGE != 0);
endmodule
